// File: rtl/memory_adaptor.sv
// Byte-serial memory adaptor: arbitrates instruction fetch and load/store
// requests onto a byte-wide synchronous RAM/IO bus and returns assembled words.
module memory_adaptor #(
  parameter logic [31:0] IO_BASE   = 32'h0003_0000,
  parameter int          INS_BYTES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        request_ins_from_memory_adaptor,
  input  logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
  output logic [31:0] ins_fetched_from_memory_adaptor,
  output logic        insfetch_task_done,
  input  logic        data_request,
  input  logic        data_is_write,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic        data_signed,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_task_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {K_IFETCH, K_LOAD, K_STORE} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nbeat_q, nbeat_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  lane;
  logic [31:0] beat_addr;
  logic        io_stall;

  function automatic logic [2:0] beats_of(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                              input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (size)
      2'd0:    return sgn ? 32'(b) : {24'd0, raw[7:0]};
      2'd1:    return sgn ? 32'(h) : {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign ins_fetched_from_memory_adaptor = ins_q;
  assign data_rdata                      = rdata_q;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    nbeat_d = nbeat_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    ins_d   = ins_q;
    rdata_d = rdata_q;
    mem_a   = '0;
    mem_dout = '0;
    mem_wr  = 1'b0;
    insfetch_task_done = 1'b0;
    data_task_done     = 1'b0;
    lane      = cnt_q[1:0] - 2'd1;
    beat_addr = addr_q + {29'd0, cnt_q};
    io_stall  = io_buffer_full && (beat_addr >= IO_BASE);

    case (state_q)
      S_IDLE: begin
        if (rdy_in && !flush_pipline) begin
          if (data_request) begin
            kind_d  = data_is_write ? K_STORE : K_LOAD;
            state_d = data_is_write ? S_WRITE : S_READ;
            addr_d  = data_addr;
            size_d  = data_size;
            sgn_d   = data_signed;
            wdata_d = data_wdata;
            nbeat_d = beats_of(data_size);
            cnt_d   = '0;
          end else if (request_ins_from_memory_adaptor) begin
            kind_d  = K_IFETCH;
            state_d = S_READ;
            addr_d  = insaddr_to_be_fetched_from_memory_adaptor;
            size_d  = 2'd2;
            sgn_d   = 1'b0;
            nbeat_d = 3'(INS_BYTES);
            cnt_d   = '0;
          end
        end
      end
      // One extra cycle after the last address beat collects the final byte.
      S_READ: begin
        if (cnt_q < nbeat_q) mem_a = beat_addr;
        if (rdy_in) begin
          if (flush_pipline) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            if (cnt_q != 3'd0) buf_d[{lane, 3'b000} +: 8] = mem_din;
            if (cnt_q == nbeat_q) begin
              state_d = S_DONE;
              cnt_d   = '0;
              if (kind_q == K_IFETCH) ins_d = buf_d;
              else rdata_d = extend_load(buf_d, size_q, sgn_q);
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end
      S_WRITE: begin
        mem_a    = beat_addr;
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (rdy_in && !io_stall) begin
          mem_wr = 1'b1;
          if (cnt_q == nbeat_q - 3'd1) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        if (rdy_in) begin
          state_d = S_IDLE;
          if (kind_q == K_IFETCH) insfetch_task_done = 1'b1;
          else data_task_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ins_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ins_q   <= ins_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_in) begin
    kind_q  <= kind_d;
    nbeat_q <= nbeat_d;
    addr_q  <= addr_d;
    size_q  <= size_d;
    sgn_q   <= sgn_d;
    wdata_q <= wdata_d;
    buf_q   <= buf_d;
  end

endmodule

// File: tb/tb_memory_adaptor.sv
// Directed bench for memory_adaptor with a byte-wide synchronous RAM model.
module tb_memory_adaptor;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush_pipline = 1'b0;
  logic        ireq = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] ins;
  logic        ins_done;
  logic        dreq = 1'b0;
  logic        dwr = 1'b0;
  logic [31:0] daddr = '0;
  logic [1:0]  dsize = '0;
  logic        dsgn = 1'b0;
  logic [31:0] dwdata = '0;
  logic [31:0] drdata;
  logic        ddone;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full = 1'b0;

  logic [7:0]  ram [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_a = '0;
  logic [7:0]  pl_d = '0;
  logic [31:0] wr_a [0:15];
  logic [7:0]  wr_d [0:15];
  int          wr_cnt = 0;
  int          ins_done_cnt = 0;
  int          total = 0;
  int          bad = 0;

  memory_adaptor dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .request_ins_from_memory_adaptor(ireq),
    .insaddr_to_be_fetched_from_memory_adaptor(iaddr),
    .ins_fetched_from_memory_adaptor(ins), .insfetch_task_done(ins_done),
    .data_request(dreq), .data_is_write(dwr), .data_addr(daddr), .data_size(dsize),
    .data_signed(dsgn), .data_wdata(dwdata), .data_rdata(drdata), .data_task_done(ddone),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[15:0]];
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wr_a[wr_cnt[3:0]] <= mem_a;
      wr_d[wr_cnt[3:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
    if (ins_done) ins_done_cnt <= ins_done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk_in); #1;
    pl_en = 1'b0;
  endtask

  // Call at #1 after a rising edge with the request just raised; accept is the next edge.
  task automatic wait_done(input string tag, input bit want_ins, input int exp_lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk_in);
      n++;
      if (want_ins ? ins_done : ddone) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk({tag, "_lat"}, 32'(n - 1), 32'(exp_lat));
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    @(posedge clk_in); #1;
    dreq = 1'b1; dwr = 1'b0; daddr = a; dsize = sz; dsgn = sg;
  endtask

  task automatic release_req();
    @(posedge clk_in); #1;
    dreq = 1'b0; ireq = 1'b0;
  endtask

  initial begin
    int base_ins;
    int base_wr;
    poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
    poke(16'h0204, 8'h80);
    poke(16'h0300, 8'h34); poke(16'h0301, 8'h92);
    poke(16'h0000, 8'h93); poke(16'h0001, 8'h00); poke(16'h0002, 8'h10); poke(16'h0003, 8'h00);
    poke(16'h0500, 8'hEF); poke(16'h0501, 8'hBE); poke(16'h0502, 8'hAD); poke(16'h0503, 8'hDE);

    @(negedge clk_in);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_done", {30'd0, ins_done, ddone}, 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_rdata", drdata, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Word instruction fetch with per-beat address check
    @(posedge clk_in); #1;
    ireq = 1'b1; iaddr = 32'h100;
    @(posedge clk_in);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk($sformatf("if_a%0d", i), mem_a, 32'h100 + 32'(i));
      chk($sformatf("if_wr%0d", i), {31'd0, mem_wr}, 32'd0);
    end
    @(negedge clk_in);
    chk("if_early_done", {31'd0, ins_done}, 32'd0);
    @(negedge clk_in);
    chk("if_done", {31'd0, ins_done}, 32'd1);
    chk("if_val", ins, 32'h0000_0513);
    release_req();
    @(negedge clk_in);
    chk("if_pulse_one", {31'd0, ins_done}, 32'd0);

    // Byte / half loads with extension
    load(32'h204, 2'd0, 1'b1);
    wait_done("lb_s", 1'b0, 3);
    chk("lb_s_val", drdata, 32'hFFFF_FF80);
    release_req();
    load(32'h204, 2'd0, 1'b0);
    wait_done("lb_u", 1'b0, 3);
    chk("lb_u_val", drdata, 32'h0000_0080);
    release_req();
    load(32'h300, 2'd1, 1'b1);
    wait_done("lh_s", 1'b0, 4);
    chk("lh_s_val", drdata, 32'hFFFF_9234);
    release_req();

    // Simultaneous ifetch and word store: store wins
    base_ins = ins_done_cnt;
    base_wr  = wr_cnt;
    @(posedge clk_in); #1;
    ireq = 1'b1; iaddr = 32'h400;
    dreq = 1'b1; dwr = 1'b1; daddr = 32'h400; dsize = 2'd2; dwdata = 32'h1234_5678;
    wait_done("sw", 1'b0, 5);
    chk("sw_no_if", 32'(ins_done_cnt - base_ins), 32'd0);
    chk("sw_beats", 32'(wr_cnt - base_wr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw_a%0d", i), wr_a[(base_wr + i) % 16], 32'h400 + 32'(i));
    end
    chk("sw_d0", {24'd0, wr_d[(base_wr + 0) % 16]}, 32'h78);
    chk("sw_d1", {24'd0, wr_d[(base_wr + 1) % 16]}, 32'h56);
    chk("sw_d2", {24'd0, wr_d[(base_wr + 2) % 16]}, 32'h34);
    chk("sw_d3", {24'd0, wr_d[(base_wr + 3) % 16]}, 32'h12);
    @(posedge clk_in); #1;
    dreq = 1'b0; dwr = 1'b0;
    wait_done("if_after_sw", 1'b1, 6);
    chk("if_after_sw_val", ins, 32'h1234_5678);
    release_req();

    // Flush during second beat of an ifetch
    base_ins = ins_done_cnt;
    @(posedge clk_in); #1;
    ireq = 1'b1; iaddr = 32'h100;
    @(posedge clk_in);
    @(posedge clk_in); #1;
    flush_pipline = 1'b1; ireq = 1'b0;
    @(negedge clk_in);
    chk("fl_beat1_a", mem_a, 32'h101);
    @(posedge clk_in); #1;
    flush_pipline = 1'b0;
    @(negedge clk_in);
    chk("fl_idle_a", mem_a, 32'd0);
    repeat (8) @(negedge clk_in);
    chk("fl_no_done", 32'(ins_done_cnt - base_ins), 32'd0);
    @(posedge clk_in); #1;
    ireq = 1'b1; iaddr = 32'h0;
    wait_done("fl_refetch", 1'b1, 6);
    chk("fl_refetch_val", ins, 32'h0010_0093);
    release_req();

    // IO byte store stalled by a full output buffer
    base_wr = wr_cnt;
    @(posedge clk_in); #1;
    dreq = 1'b1; dwr = 1'b1; daddr = 32'h0003_0000; dsize = 2'd0; dwdata = 32'h0000_00A5;
    io_full = 1'b1;
    @(posedge clk_in);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk($sformatf("io_stall%0d", i), {31'd0, mem_wr}, 32'd0);
    end
    @(posedge clk_in); #1;
    io_full = 1'b0;
    @(negedge clk_in);
    chk("io_wr", {31'd0, mem_wr}, 32'd1);
    chk("io_a", mem_a, 32'h0003_0000);
    chk("io_dout", {24'd0, mem_dout}, 32'hA5);
    @(negedge clk_in);
    chk("io_done", {31'd0, ddone}, 32'd1);
    chk("io_beats", 32'(wr_cnt - base_wr), 32'd1);
    @(posedge clk_in); #1;
    dreq = 1'b0; dwr = 1'b0;

    // Asynchronous reset in the middle of a word read
    load(32'h500, 2'd2, 1'b0);
    @(posedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("ar_pre_a", mem_a, 32'h501);
    #2;
    rst_in = 1'b1;
    #1;
    chk("ar_mem_a", mem_a, 32'd0);
    chk("ar_ins", ins, 32'd0);
    chk("ar_rdata", drdata, 32'd0);
    chk("ar_ctl", {29'd0, mem_wr, ins_done, ddone}, 32'd0);
    dreq = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    load(32'h500, 2'd2, 1'b0);
    wait_done("ar_lw", 1'b0, 6);
    chk("ar_lw_val", drdata, 32'hDEAD_BEEF);
    release_req();

    repeat (2) @(posedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
